// File: rtl/cpu_pkg.sv
// Shared opcode map, state encoding and per-state control decode for the CPU sequencer.
// Latency: combinational helpers only.
// Backpressure: none.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_SHRA = 5'd6;
    localparam logic [4:0] OP_SHL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_ROL  = 5'd9;
    localparam logic [4:0] OP_AND  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        IC_RTYPE, IC_IMM, IC_MULDIV, IC_UNARY, IC_LD, IC_LDI, IC_ST, IC_ILLEGAL
    } iclass_t;

    // ir[31:15]; the low immediate bits never steer the sequencer.
    typedef struct packed {
        logic [4:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } instr_t;

    typedef struct packed {
        logic       pc_out;
        logic       zlo_out;
        logic       zhi_out;
        logic       mdr_out;
        logic       c_out;
        logic       mar_enable;
        logic       z_enable;
        logic       lo_enable;
        logic       hi_enable;
        logic       pc_enable;
        logic       mdr_enable;
        logic       ir_enable;
        logic       y_enable;
        logic       pc_increment;
        logic       read;
        logic       write;
        logic       reg_out_en;
        logic [3:0] reg_out_sel;
        logic       reg_in_en;
        logic [3:0] reg_in_sel;
        logic [4:0] op_code;
        logic       run;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_t s, iclass_t c, instr_t f);
        ctrl_t o;
        o     = '0;
        o.run = (s != ST_RESET) && (s != ST_HALT);
        case (s)
            ST_T0: begin
                o.pc_out = 1'b1; o.mar_enable = 1'b1; o.pc_increment = 1'b1; o.z_enable = 1'b1;
            end
            ST_T1: begin
                o.zlo_out = 1'b1; o.pc_enable = 1'b1; o.read = 1'b1; o.mdr_enable = 1'b1;
            end
            ST_T2: begin
                o.mdr_out = 1'b1; o.ir_enable = 1'b1;
            end
            ST_T3: case (c)
                IC_MULDIV: begin o.reg_out_en = 1'b1; o.reg_out_sel = f.ra; o.y_enable = 1'b1; end
                IC_UNARY:  begin o.reg_out_en = 1'b1; o.reg_out_sel = f.rb; o.op_code = f.op; o.z_enable = 1'b1; end
                IC_ILLEGAL: begin end
                default:   begin o.reg_out_en = 1'b1; o.reg_out_sel = f.rb; o.y_enable = 1'b1; end
            endcase
            ST_T4: case (c)
                IC_RTYPE:  begin o.reg_out_en = 1'b1; o.reg_out_sel = f.rc; o.op_code = f.op; o.z_enable = 1'b1; end
                IC_IMM:    begin o.c_out = 1'b1; o.op_code = f.op; o.z_enable = 1'b1; end
                IC_MULDIV: begin o.reg_out_en = 1'b1; o.reg_out_sel = f.rb; o.op_code = f.op; o.z_enable = 1'b1; end
                IC_UNARY:  begin o.zlo_out = 1'b1; o.reg_in_en = 1'b1; o.reg_in_sel = f.ra; end
                IC_LD, IC_LDI, IC_ST: begin o.c_out = 1'b1; o.op_code = OP_ADD; o.z_enable = 1'b1; end
                default:   begin end
            endcase
            ST_T5: case (c)
                IC_RTYPE, IC_IMM, IC_LDI: begin o.zlo_out = 1'b1; o.reg_in_en = 1'b1; o.reg_in_sel = f.ra; end
                IC_MULDIV: begin o.zlo_out = 1'b1; o.lo_enable = 1'b1; end
                IC_LD, IC_ST: begin o.zlo_out = 1'b1; o.mar_enable = 1'b1; end
                default:   begin end
            endcase
            ST_T6: case (c)
                IC_MULDIV: begin o.zhi_out = 1'b1; o.hi_enable = 1'b1; end
                IC_LD:     begin o.read = 1'b1; o.mdr_enable = 1'b1; end
                IC_ST:     begin o.reg_out_en = 1'b1; o.reg_out_sel = f.ra; o.mdr_enable = 1'b1; end
                default:   begin end
            endcase
            ST_T7: case (c)
                IC_LD:     begin o.mdr_out = 1'b1; o.reg_in_en = 1'b1; o.reg_in_sel = f.ra; end
                IC_ST:     begin o.write = 1'b1; end
                default:   begin end
            endcase
            default: begin end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Maps a 5-bit opcode onto the instruction class that selects the execute sequence.
// Latency: combinational.
// Backpressure: none.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [4:0] op,
    output iclass_t    iclass
);

    always_comb begin
        iclass = IC_ILLEGAL;
        if (op == OP_LD)
            iclass = IC_LD;
        else if (op == OP_LDI)
            iclass = IC_LDI;
        else if (op == OP_ST)
            iclass = IC_ST;
        else if (op <= OP_OR)
            iclass = IC_RTYPE;
        else if (op <= OP_ORI)
            iclass = IC_IMM;
        else if (op == OP_DIV || op == OP_MUL)
            iclass = IC_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)
            iclass = IC_UNARY;
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, class-specific execute T3-T7, HALT on stop or illegal op.
// Latency: outputs are registered and valid in the cycle the state is entered.
// Backpressure: none; stop only acts at instruction end, clr aborts immediately.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        mdr_out,
    output logic        c_out,
    output logic        mar_enable,
    output logic        z_enable,
    output logic        lo_enable,
    output logic        hi_enable,
    output logic        pc_enable,
    output logic        mdr_enable,
    output logic        ir_enable,
    output logic        y_enable,
    output logic        pc_increment,
    output logic        read,
    output logic        write,
    output logic        reg_out_en,
    output logic [3:0]  reg_out_sel,
    output logic        reg_in_en,
    output logic [3:0]  reg_in_sel,
    output logic [4:0]  op_code,
    output logic        run
);

    state_t  state;
    state_t  nxt;
    state_t  after_last;
    instr_t  ir_f;
    instr_t  ir_q;
    instr_t  cur;
    iclass_t cls;
    ctrl_t   ctl;
    logic    armed;
    logic    ir_unused;

    assign ir_f      = ir[31:15];
    assign ir_unused = ^ir[14:0];

    // The external IR is loaded during T2, so decode from it directly then and from the copy afterwards.
    assign cur        = (state == ST_T2) ? ir_f : ir_q;
    assign after_last = stop ? ST_HALT : ST_T0;

    instr_decode u_decode (
        .op     (cur.op),
        .iclass (cls)
    );

    always_comb begin
        nxt = state;
        case (state)
            ST_RESET: nxt = armed ? ST_T0 : ST_RESET;
            ST_T0:    nxt = ST_T1;
            ST_T1:    nxt = ST_T2;
            ST_T2:    nxt = ST_T3;
            ST_T3:    nxt = (cls == IC_ILLEGAL) ? ST_HALT : ST_T4;
            ST_T4:    nxt = (cls == IC_UNARY) ? after_last : ST_T5;
            ST_T5:    nxt = (cls inside {IC_RTYPE, IC_IMM, IC_LDI}) ? after_last : ST_T6;
            ST_T6:    nxt = (cls == IC_MULDIV) ? after_last : ST_T7;
            ST_T7:    nxt = after_last;
            default:  nxt = ST_HALT;
        endcase
    end

    // armed delays the first T0 to the second edge after clr releases.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_RESET;
            armed <= 1'b0;
            ir_q  <= '0;
            ctl   <= '0;
        end else begin
            armed <= 1'b1;
            state <= nxt;
            ir_q  <= cur;
            ctl   <= ctrl_for(nxt, cls, cur);
        end
    end

    assign pc_out       = ctl.pc_out;
    assign zlo_out      = ctl.zlo_out;
    assign zhi_out      = ctl.zhi_out;
    assign mdr_out      = ctl.mdr_out;
    assign c_out        = ctl.c_out;
    assign mar_enable   = ctl.mar_enable;
    assign z_enable     = ctl.z_enable;
    assign lo_enable    = ctl.lo_enable;
    assign hi_enable    = ctl.hi_enable;
    assign pc_enable    = ctl.pc_enable;
    assign mdr_enable   = ctl.mdr_enable;
    assign ir_enable    = ctl.ir_enable;
    assign y_enable     = ctl.y_enable;
    assign pc_increment = ctl.pc_increment;
    assign read         = ctl.read;
    assign write        = ctl.write;
    assign reg_out_en   = ctl.reg_out_en;
    assign reg_out_sel  = ctl.reg_out_sel;
    assign reg_in_en    = ctl.reg_in_en;
    assign reg_in_sel   = ctl.reg_in_sel;
    assign op_code      = ctl.op_code;
    assign run          = ctl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then random instruction streams with stop/clr,
// compared every cycle against a per-instruction micro-step list model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        stop;
    logic [31:0] ir;
    logic        pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic        mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable;
    logic        ir_enable, y_enable, pc_increment, read, write;
    logic        reg_out_en, reg_in_en, run;
    logic [3:0]  reg_out_sel, reg_in_sel;
    logic [4:0]  op_code;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out), .c_out(c_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .lo_enable(lo_enable), .hi_enable(hi_enable),
        .pc_enable(pc_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
        .pc_increment(pc_increment), .read(read), .write(write),
        .reg_out_en(reg_out_en), .reg_out_sel(reg_out_sel), .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
        .op_code(op_code), .run(run)
    );

    typedef struct packed {
        logic       pc_out, zlo_out, zhi_out, mdr_out, c_out;
        logic       mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable;
        logic       ir_enable, y_enable, pc_increment, read, write;
        logic       reg_out_en;
        logic [3:0] reg_out_sel;
        logic       reg_in_en;
        logic [3:0] reg_in_sel;
        logic [4:0] op_code;
        logic       run;
    } sig_t;

    typedef struct {
        logic [31:0] ir;
        int          stop_from;
        int          stop_to;
        int          clr_at;
        int          hwait;
    } dir_t;

    localparam int MS_RESET = 0;
    localparam int MS_RUN   = 1;
    localparam int MS_HALT  = 2;
    localparam int TARGET   = 400;

    int          vectors = 0;
    int          miscompares = 0;
    sig_t        steps[$];
    dir_t        dq[$];
    dir_t        cur_d;
    bit          directed;
    logic [31:0] cur_ir;
    bit          m_illegal;
    int          ms, rcnt, idx, halt_cnt, instr_count;
    int          len, len_valid, len_dir;
    logic [31:0] len_ir;

    function automatic sig_t sample();
        sig_t s;
        s = '{pc_out, zlo_out, zhi_out, mdr_out, c_out, mar_enable, z_enable, lo_enable, hi_enable,
              pc_enable, mdr_enable, ir_enable, y_enable, pc_increment, read, write,
              reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, op_code, run};
        return s;
    endfunction

    task automatic check(input string name, input sig_t got, input sig_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h (ir %h step %0d)", name, $time, got, want, cur_ir, idx);
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    function automatic sig_t blank();
        sig_t s = '0;
        s.run = 1'b1;
        return s;
    endfunction

    // Micro-step list for one instruction: three fetch steps, then the execute steps of its opcode.
    task automatic build_steps(input logic [31:0] w);
        sig_t s;
        int   op, ra, rb, rc;
        op = int'(w[31:27]); ra = int'(w[26:23]); rb = int'(w[22:19]); rc = int'(w[18:15]);
        steps = {};
        s = blank(); s.pc_out = 1; s.mar_enable = 1; s.pc_increment = 1; s.z_enable = 1; steps.push_back(s);
        s = blank(); s.zlo_out = 1; s.pc_enable = 1; s.read = 1; s.mdr_enable = 1; steps.push_back(s);
        s = blank(); s.mdr_out = 1; s.ir_enable = 1; steps.push_back(s);
        m_illegal = (op > 18);
        if (op >= 3 && op <= 14) begin
            s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(rb); s.y_enable = 1; steps.push_back(s);
            s = blank();
            if (op <= 11) begin s.reg_out_en = 1; s.reg_out_sel = 4'(rc); end
            else s.c_out = 1;
            s.op_code = 5'(op); s.z_enable = 1; steps.push_back(s);
            s = blank(); s.zlo_out = 1; s.reg_in_en = 1; s.reg_in_sel = 4'(ra); steps.push_back(s);
        end else if (op == 15 || op == 16) begin
            s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(ra); s.y_enable = 1; steps.push_back(s);
            s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(rb); s.op_code = 5'(op); s.z_enable = 1; steps.push_back(s);
            s = blank(); s.zlo_out = 1; s.lo_enable = 1; steps.push_back(s);
            s = blank(); s.zhi_out = 1; s.hi_enable = 1; steps.push_back(s);
        end else if (op == 17 || op == 18) begin
            s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(rb); s.op_code = 5'(op); s.z_enable = 1; steps.push_back(s);
            s = blank(); s.zlo_out = 1; s.reg_in_en = 1; s.reg_in_sel = 4'(ra); steps.push_back(s);
        end else if (op <= 2) begin
            s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(rb); s.y_enable = 1; steps.push_back(s);
            s = blank(); s.c_out = 1; s.op_code = 5'd3; s.z_enable = 1; steps.push_back(s);
            if (op == 1) begin
                s = blank(); s.zlo_out = 1; s.reg_in_en = 1; s.reg_in_sel = 4'(ra); steps.push_back(s);
            end else begin
                s = blank(); s.zlo_out = 1; s.mar_enable = 1; steps.push_back(s);
                if (op == 0) begin
                    s = blank(); s.read = 1; s.mdr_enable = 1; steps.push_back(s);
                    s = blank(); s.mdr_out = 1; s.reg_in_en = 1; s.reg_in_sel = 4'(ra); steps.push_back(s);
                end else begin
                    s = blank(); s.reg_out_en = 1; s.reg_out_sel = 4'(ra); s.mdr_enable = 1; steps.push_back(s);
                    s = blank(); s.write = 1; steps.push_back(s);
                end
            end
        end else begin
            steps.push_back(blank());
        end
    endtask

    task automatic start_instr();
        logic [31:0] r;
        if (dq.size() > 0) begin
            cur_d    = dq.pop_front();
            directed = 1;
        end else begin
            directed = 0;
            r = $urandom;
            r[31:27] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
            cur_d = '{r, -1, -1, -1, int'($urandom_range(1, 4))};
        end
        ir     = cur_d.ir;
        cur_ir = cur_d.ir;
        build_steps(cur_d.ir);
        idx = 0;
        ms  = MS_RUN;
        instr_count++;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1;
        check("clr_async", sample(), '0);
    endtask

    task automatic check_cycle();
        sig_t a;
        a = sample();
        check("cycle", a, (ms == MS_RUN) ? steps[idx] : sig_t'('0));
        if (directed && ms == MS_RUN) begin
            if (cur_ir == 32'h81300000) begin
                if (idx == 3) pin("mul_t3_rsel", int'(a.reg_out_sel), 2);
                if (idx == 4) begin pin("mul_t4_rsel", int'(a.reg_out_sel), 6); pin("mul_t4_op", int'(a.op_code), 16); end
                if (idx == 5) pin("mul_t5_lo", int'(a.lo_enable), 1);
                if (idx == 6) pin("mul_t6_hi", int'(a.hi_enable), 1);
            end else if (cur_ir == 32'h1A130000) begin
                if (idx == 3) pin("add_t3_rsel", int'(a.reg_out_sel), 2);
                if (idx == 4) begin pin("add_t4_rsel", int'(a.reg_out_sel), 6); pin("add_t4_op", int'(a.op_code), 3); end
                if (idx == 5) pin("add_t5_wsel", int'(a.reg_in_sel), 4);
            end else if (cur_ir == 32'h09800025) begin
                if (idx == 4) begin pin("ldi_t4_c", int'(a.c_out), 1); pin("ldi_t4_op", int'(a.op_code), 3); end
                if (idx == 5) pin("ldi_t5_wsel", int'(a.reg_in_sel), 3);
            end
        end
        if (directed && ms == MS_HALT) pin("halt_run", int'(a.run), 0);
        // Instruction length as seen on the DUT: cycles from one pc_out pulse to the next.
        if (!a.run) len_valid = 0;
        else if (a.pc_out) begin
            if (len_valid != 0 && len_dir != 0) begin
                if (len_ir == 32'h81300000) pin("mul_cycles", len, 7);
                else if (len_ir == 32'h1A130000) pin("add_cycles", len, 6);
            end
            len = 1; len_valid = 1; len_ir = cur_ir; len_dir = directed ? 1 : 0;
        end else len++;
    endtask

    task automatic drive();
        if (ms == MS_RESET) begin
            if (clr) clr = 1'b0;
            stop = 1'($urandom_range(0, 1));
        end else if (ms == MS_HALT) begin
            stop = 1'b0;
            halt_cnt++;
            if (halt_cnt >= cur_d.hwait) pulse_clr();
        end else begin
            if (directed) stop = (cur_d.stop_from >= 0 && idx >= cur_d.stop_from && idx <= cur_d.stop_to);
            else stop = ($urandom_range(0, 5) == 0);
            if ((directed && idx == cur_d.clr_at) || (!directed && $urandom_range(0, 79) == 0)) pulse_clr();
        end
    endtask

    task automatic advance();
        if (clr) begin
            ms = MS_RESET; rcnt = 0;
        end else if (ms == MS_RESET) begin
            if (rcnt == 0) rcnt = 1;
            else start_instr();
        end else if (ms == MS_RUN) begin
            if (idx < steps.size() - 1) idx++;
            else if (m_illegal || stop) begin ms = MS_HALT; halt_cnt = 0; end
            else start_instr();
        end
    endtask

    initial begin
        clr = 1'b1; stop = 1'b0; ir = '0;
        ms = MS_RESET; rcnt = 0; idx = 0; halt_cnt = 0; instr_count = 0;
        len = 0; len_valid = 0; len_dir = 0; len_ir = '0; cur_ir = '0; directed = 0; m_illegal = 0;
        cur_d = '{32'h0, -1, -1, -1, 1};
        dq.push_back('{32'h81300000, -1, -1, -1, 3});   // mul R2,R6
        dq.push_back('{32'h1A130000, -1, -1, -1, 3});   // add R4,R2,R6
        dq.push_back('{32'h09800025, -1, -1, -1, 3});   // ldi R3,0x25(R0)
        dq.push_back('{32'h02800000, -1, -1, -1, 3});   // ld R5
        dq.push_back('{32'h13800000, -1, -1, -1, 3});   // st R7
        dq.push_back('{32'h88900000, -1, -1, -1, 3});   // neg R1,R2
        dq.push_back('{32'h91180000, -1, -1, -1, 3});   // not R2,R3
        dq.push_back('{32'h60901234, -1, -1, -1, 3});   // addi R1,R2,0x1234
        dq.push_back('{32'h79A00000, -1, -1, -1, 3});   // div R3,R4
        dq.push_back('{32'h1A130000,  0,  0, -1, 3});   // add, stop only in T0
        dq.push_back('{32'h81300000,  4, 99, -1, 3});   // mul, stop from T4 onward
        dq.push_back('{32'h02800000, -1, -1,  5, 3});   // ld, clr in T5
        dq.push_back('{32'hA0000000, -1, -1, -1, 10});  // op 20
        #1;
        check("reset", sample(), '0);
        for (int cyc = 0; cyc < 30000 && instr_count < TARGET; cyc++) begin
            @(negedge clk);
            check_cycle();
            drive();
            advance();
        end
        vectors++;
        if (instr_count < TARGET) begin
            miscompares++;
            $display("FAIL budget: %0d instructions started, needed %0d", instr_count, TARGET);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 clr  input  1  asynchronous active-high reset.
REQ-004 ir  input  32  instruction register contents: op[31:27], ra[26:23], rb[22:19], rc[18:15], c[18:0].
REQ-005 stop  input  1  halt request, sampled only at instruction boundaries.
REQ-006 pc_out, zlo_out, zhi_out, mdr_out, c_out  output  1 each  bus-drive selects.
REQ-007 mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable, ir_enable, y_enable, pc_increment, read, write  output  1 each  register load and memory strobes.
REQ-008 reg_out_en  output  1, and reg_out_sel  output  4  general-register bus drive and its index.
REQ-009 reg_in_en  output  1, and reg_in_sel  output  4  general-register load and its index.
REQ-010 op_code  output  5  ALU operation; it SHALL be 0 except in the state that loads Z.
REQ-011 run  output  1  high in every state except RESET and HALT.

Function
REQ-012 The block SHALL be a Moore FSM with states RESET, T0–T7 and HALT, one clock per state, and outputs decoded from the state plus the latched ir.
REQ-013 Any output not listed for a state SHALL be 0 in that state.
REQ-014 RESET SHALL drive all outputs to 0 and go to T0 on the next edge.
REQ-015 Fetch SHALL proceed as:
- T0: pc_out, mar_enable, pc_increment, z_enable.
- T1: zlo_out, pc_enable, read, mdr_enable.
- T2: mdr_out, ir_enable.
REQ-016 R-type ops 3–11 SHALL use:
- T3: reg_out=rb, y_enable.
- T4: reg_out=rc, op_code=op, z_enable.
- T5: zlo_out, reg_in=ra.
REQ-017 Immediate ops 12–14 SHALL follow REQ-016 except that T4 drives c_out instead of reg_out.
REQ-018 div/mul (15, 16) SHALL use:
- T3: reg_out=ra, y_enable.
- T4: reg_out=rb, op_code=op, z_enable.
- T5: zlo_out, lo_enable.
- T6: zhi_out, hi_enable.
REQ-019 neg/not (17, 18) SHALL use:
- T3: reg_out=rb, op_code=op, z_enable.
- T4: zlo_out, reg_in=ra.
REQ-020 ldi (1) SHALL use:
- T3: reg_out=rb, y_enable.
- T4: c_out, op_code=3, z_enable.
- T5: zlo_out, reg_in=ra.
REQ-021 ld (0) SHALL follow ldi through T4, then:
- T5: zlo_out, mar_enable.
- T6: read, mdr_enable.
- T7: mdr_out, reg_in=ra.
REQ-022 st (2) SHALL follow ld through T5, then:
- T6: reg_out=ra, mdr_enable with read=0.
- T7: write.
REQ-023 After the last step of any opcode, the next state SHALL be HALT if stop=1, else T0.
REQ-024 Opcodes 19–31, decoded in T2, SHALL go from T3 to HALT with all outputs 0.
REQ-025 HALT SHALL hold with run=0 until clr.
REQ-026 Instruction cycle counts SHALL be: fetch 3; neg/not 5; R-type, immediate and ldi 6; mul/div 7; ld/st 8.
REQ-027 stop SHALL be ignored mid-instruction.

Reset
REQ-028 Asserting clr at any point, including mid-instruction, SHALL force RESET immediately with all outputs 0 and run=0.
REQ-029 The first T0 SHALL occur on the second rising edge after clr deasserts.

Structure
REQ-030 Opcode parameters (ld=0 … not=18) and the state encoding SHALL live in the shared package cpu_pkg.
REQ-031 One sub-module, instr_decode, SHALL map op to an instruction class (RTYPE, IMM, MULDIV, UNARY, LD, LDI, ST, ILLEGAL).

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- ir=0x81300000 (mul R2,R6) → T3 reg_out_sel=2, T4 reg_out_sel=6 with op_code=16, T5 lo_enable, T6 hi_enable, then T0.
- ir=0x1A130000 (add R4,R2,R6) → T3 sel=2, T4 sel=6 with op_code=3, T5 reg_in_sel=4, and 6 cycles total.
- ir=0x09800025 (ldi R3,0x25(R0)) → T4 c_out with op_code=3, T5 reg_in_sel=3.
- ir=0xA0000000 (op 20) → HALT after T3, run=0, and every output stays 0 for 10 cycles.
- stop=1 asserted during T4 of mul → completes T6 then HALT; stop=1 during T0 is ignored.
- clr pulsed during T5 of ld → all outputs 0 in the same cycle; T0 follows on the second edge after release.
